// File: rtl/alu_stream_pkg.sv
// alu_stream_pkg: opcodes, illegal-result constant and shared helpers
// for the handshaked ALU stream unit.
package alu_stream_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h5,
    OP_OR  = 4'h6,
    OP_XOR = 4'h7
  } opcode_e;

  localparam logic [15:0] ILLEGAL_RESULT = 16'hBAD1;

  // Result flags carried next to the WIDTH-bit result in each entry.
  typedef struct packed {
    logic carry_out;
    logic illegal;
  } res_flags_t;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    ok = 1'b0;
    unique case (op)
      OP_ADD, OP_SUB,
      OP_AND, OP_OR,
      OP_XOR:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_stream_fifo.sv
// alu_stream_fifo: synchronous FIFO with occupancy count, full and empty.
// Ports: push/push_data in, pop/pop_data out, count/full/empty status.
module alu_stream_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is allowed only when the head leaves
  // on the same edge.
  assign do_push = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_stream_unit.sv
// alu_stream_unit: registered ALU with valid/ready command and result
// streams, result FIFO, and saturating op/illegal counters.
module alu_stream_unit
  import alu_stream_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [WIDTH-1:0] in_operand_a,
  input  logic [WIDTH-1:0] in_operand_b,
  input  logic             in_carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry_out,
  output logic             out_illegal,
  output logic [15:0]      op_count,
  output logic [7:0]       illegal_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    res_flags_t       flags;
  } res_t;

  logic             rdy_en;
  logic             accept;
  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_cin;
  logic [WIDTH:0]   wide;
  res_t             s2_res;
  res_t             head;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW:0]      credit_used;

  // Credits cover FIFO entries plus the one in flight in S1, so the
  // S1 result always finds room and S1 never stalls.
  assign credit_used = {1'b0, fifo_count}
                     + {{CW{1'b0}}, s1_valid};
  assign in_ready = rdy_en && !fifo_full
                 && (credit_used < DEPTH_C);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op  <= in_opcode;
        s1_a   <= in_operand_a;
        s1_b   <= in_operand_b;
        s1_cin <= in_carry_in;
      end
    end
  end

  always_comb begin
    s2_res = '0;
    wide   = '0;
    unique case (s1_op)
      OP_ADD: begin
        wide = {1'b0, s1_a} + {1'b0, s1_b}
             + {{WIDTH{1'b0}}, s1_cin};
        s2_res.result          = wide[WIDTH-1:0];
        s2_res.flags.carry_out = wide[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the WIDTH+1 difference is the borrow.
        wide = {1'b0, s1_a} - {1'b0, s1_b}
             - {{WIDTH{1'b0}}, s1_cin};
        s2_res.result          = wide[WIDTH-1:0];
        s2_res.flags.carry_out = wide[WIDTH];
      end
      OP_AND: s2_res.result = s1_a & s1_b;
      OP_OR:  s2_res.result = s1_a | s1_b;
      OP_XOR: s2_res.result = s1_a ^ s1_b;
      default: begin
        s2_res.result        = WIDTH'(ILLEGAL_RESULT);
        s2_res.flags.illegal = 1'b1;
      end
    endcase
  end

  alu_stream_fifo #(
    .DW    ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (s1_valid),
    .push_data (s2_res),
    .pop       (out_ready),
    .pop_data  (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Outputs read as zero whenever nothing is queued.
  assign out_valid     = !fifo_empty;
  assign out_result    = out_valid ? head.result : '0;
  assign out_carry_out = out_valid && head.flags.carry_out;
  assign out_illegal   = out_valid && head.flags.illegal;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count      <= '0;
      illegal_count <= '0;
    end else if (accept) begin
      if (op_count != '1)
        op_count <= op_count + 16'd1;
      if (!op_legal(in_opcode) && illegal_count != '1)
        illegal_count <= illegal_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_stream_unit.sv
// tb_alu_stream_unit: directed and random stimulus against a queue-based
// reference model of the ALU stream unit.
module tb_alu_stream_unit;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   in_opcode = '0;
  logic [W-1:0] in_operand_a = '0;
  logic [W-1:0] in_operand_b = '0;
  logic         in_carry_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_carry_out;
  logic         out_illegal;
  logic [15:0]  op_count;
  logic [7:0]   illegal_count;

  alu_stream_unit #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_operand_a  (in_operand_a),
    .in_operand_b  (in_operand_b),
    .in_carry_in   (in_carry_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_carry_out (out_carry_out),
    .out_illegal   (out_illegal),
    .op_count      (op_count),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         il;
    int           stamp;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] seen[$];
  int n_vec = 0;
  int n_bad = 0;
  int edge_no = 0;
  int m_ops = 0;
  int m_ill = 0;
  bit live = 0;
  bit last_fire = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b,
                                 input logic ci);
    exp_t e;
    longint m, sa, sb, sc, s;
    m  = longint'(1) << W;
    sa = longint'(a);
    sb = longint'(b);
    sc = ci ? 1 : 0;
    e.c = 0; e.il = 0; e.stamp = 0; e.r = '0;
    case (op)
      4'h0: begin
        s = sa + sb + sc;
        e.r = W'(s % m);
        e.c = (s >= m);
      end
      4'h1: begin
        e.c = (sa < sb + sc);
        e.r = W'((sa - sb - sc + 2 * m) % m);
      end
      4'h5: e.r = a & b;
      4'h6: e.r = a | b;
      4'h7: e.r = a ^ b;
      default: begin
        e.r = W'(16'hBAD1);
        e.il = 1;
      end
    endcase
    return e;
  endfunction

  // One clock: check at the falling edge, update model at the rising one.
  task automatic step();
    bit   er, ev, fin, fout;
    exp_t e;
    @(negedge clk);
    er = live && (q.size() < D);
    ev = 0;
    if (q.size() > 0) ev = (edge_no >= q[0].stamp + 1);
    check("in_ready", in_ready, er);
    check("out_valid", out_valid, ev);
    check("op_count", op_count, m_ops);
    check("illegal_count", illegal_count, m_ill);
    if (ev) begin
      check("result", out_result, q[0].r);
      check("carry_out", out_carry_out, q[0].c);
      check("illegal", out_illegal, q[0].il);
    end
    fin  = in_valid && er;
    fout = out_ready && ev;
    if (fout) seen.push_back(out_result);
    @(posedge clk);
    edge_no++;
    if (fout) void'(q.pop_front());
    if (fin) begin
      e = model(in_opcode, in_operand_a, in_operand_b, in_carry_in);
      e.stamp = edge_no;
      q.push_back(e);
      if (m_ops < 65535) m_ops++;
      if (e.il && m_ill < 255) m_ill++;
    end
    live = reset_n;
    last_fire = fin;
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic ci);
    in_opcode = op;
    in_operand_a = a;
    in_operand_b = b;
    in_carry_in = ci;
  endtask

  task automatic send(input logic [3:0] op,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic ci);
    int n;
    set_cmd(op, a, b, ci);
    in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_fire && n < 50);
    if (!last_fire) check("send_timeout", 0, 1);
  endtask

  task automatic rand_cmd();
    logic [3:0] ops[5];
    logic [3:0] op;
    ops = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7};
    if ($urandom_range(0, 9) < 8) op = ops[$urandom_range(0, 4)];
    else op = 4'($urandom_range(2, 15));
    set_cmd(op, W'($urandom), W'($urandom), 1'($urandom));
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (q.size() > 0 && n < limit) begin
      step();
      n++;
    end
    if (q.size() > 0) check("drain_timeout", 0, 1);
  endtask

  logic [W-1:0] bp_a[6];
  logic [3:0]   bp_op[6];
  logic [W-1:0] want[$];

  initial begin
    int k, n;
    exp_t e;

    // Reset state
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // ADD with carry out
    out_ready = 1'b1;
    send(4'h0, 16'hFFFF, 16'h0001, 1'b0);
    in_valid = 1'b0;
    step();
    check("add_valid", out_valid, 1);
    check("add_result", out_result, 16'h0000);
    check("add_cout", out_carry_out, 1);
    check("add_op_count", op_count, 1);
    drain(10);

    // Illegal opcode
    send(4'hF, 16'h0001, 16'h0001, 1'b0);
    in_valid = 1'b0;
    step();
    check("ill_result", out_result, 16'hBAD1);
    check("ill_cout", out_carry_out, 0);
    check("ill_flag", out_illegal, 1);
    check("ill_count", illegal_count, 1);
    check("ill_op_count", op_count, 2);
    drain(10);

    // Back-to-back SUB/AND/OR/XOR
    seen.delete();
    send(4'h1, 16'h0005, 16'h0007, 1'b0);
    send(4'h5, 16'h00FF, 16'h0F0F, 1'b0);
    send(4'h6, 16'h00FF, 16'h0F0F, 1'b0);
    send(4'h7, 16'h00FF, 16'h0F0F, 1'b0);
    in_valid = 1'b0;
    drain(20);
    want = '{16'hFFFE, 16'h000F, 16'h0FFF, 16'h0FF0};
    check("b2b_count", seen.size(), 4);
    foreach (want[i])
      if (i < seen.size()) check("b2b_order", seen[i], want[i]);

    // Backpressure: six commands against a stalled consumer
    seen.delete();
    want.delete();
    for (int i = 0; i < 6; i++) begin
      bp_op[i] = (i % 2 == 0) ? 4'h0 : 4'h1;
      bp_a[i] = W'(16'h1000 + i * 16'h0111);
      e = model(bp_op[i], bp_a[i], W'(i), 1'b1);
      want.push_back(e.r);
    end
    out_ready = 1'b0;
    k = 0;
    set_cmd(bp_op[0], bp_a[0], W'(0), 1'b1);
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (last_fire) begin
        k++;
        if (k < 6) set_cmd(bp_op[k], bp_a[k], W'(k), 1'b1);
        else in_valid = 1'b0;
      end
    end
    check("bp_accepted", k, D);
    out_ready = 1'b1;
    n = 0;
    while ((k < 6 || q.size() > 0) && n < 40) begin
      step();
      n++;
      if (last_fire) begin
        k++;
        if (k < 6) set_cmd(bp_op[k], bp_a[k], W'(k), 1'b1);
        else in_valid = 1'b0;
      end
    end
    check("bp_all_out", seen.size(), 6);
    foreach (want[i])
      if (i < seen.size()) check("bp_order", seen[i], want[i]);

    // Fill, then stream with both sides active
    out_ready = 1'b0;
    in_valid = 1'b1;
    rand_cmd();
    n = 0;
    while (q.size() < D && n < 20) begin
      step();
      n++;
      if (last_fire) rand_cmd();
    end
    check("full_reached", q.size(), D);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (last_fire) rand_cmd();
    end
    in_valid = 1'b0;
    drain(20);

    // Reset with three queued results and S1 occupied
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(4'h0, W'(i), W'(i), 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_cout", out_carry_out, 0);
    check("mid_rst_illegal", out_illegal, 0);
    check("mid_rst_ops", op_count, 0);
    check("mid_rst_ill", illegal_count, 0);
    q.delete();
    m_ops = 0;
    m_ill = 0;
    live = 0;
    step();
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) step();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || last_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_cmd();
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(20);

    // Illegal counter saturation
    in_valid = 1'b1;
    for (int c = 0; c < 270; c++) begin
      set_cmd(4'($urandom_range(8, 15)), W'($urandom),
              W'($urandom), 1'b0);
      step();
    end
    in_valid = 1'b0;
    drain(20);
    check("ill_saturated", illegal_count, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
